// File: rtl/notch_inverse_equalizer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : notch_inverse_equalizer_pkg
// Brief   : Shared types and default coefficients for the notch equalizer.
// Revision: 1.0
// ============================================================================
package notch_inverse_equalizer_pkg;

    localparam int EQ_WIDTH = 16;
    localparam int EQ_ACC_W = 40;

    // Q16.16 coefficients of W(z) = D(z)/C(z); C sits on the notch zeros at r=0.995
    localparam logic [31:0] EQ_D1 = 32'hFFFE_1DF4;
    localparam logic [31:0] EQ_D2 = 32'h0000_FAE7;
    localparam logic [31:0] EQ_C1 = 32'hFFFE_1B85;
    localparam logic [31:0] EQ_C2 = 32'h0000_FD72;

    localparam logic [2:0] EQ_LAST_STEP = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        SAT  = 2'd2,
        HOLD = 2'd3
    } eq_state_t;

endpackage
`default_nettype wire

// File: rtl/notch_inverse_equalizer_fx_mac_sat.sv
`default_nettype none
// ============================================================================
// Module  : notch_inverse_equalizer_fx_mac_sat
// Brief   : Shared Q16.16 truncating multiplier, wide accumulator, clamp.
// Revision: 1.0
// ============================================================================
module notch_inverse_equalizer_fx_mac_sat #(
    parameter int WIDTH = 16,
    parameter int ACC_W = 40
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic [2*WIDTH-1:0]   a_i,
    input  logic [2*WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0]   sat_o,
    output logic                 ovf_o
);

    localparam int DW = 2 * WIDTH;

    logic [2*DW-1:0]   prod_full;
    logic [ACC_W-1:0]  prod_acc;
    logic [ACC_W-1:0]  acc_d;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-DW:0] acc_hi;
    logic              hi_same;
    logic              w_unused_prod;

    assign prod_full = $signed({{DW{a_i[DW-1]}}, a_i}) * $signed({{DW{b_i[DW-1]}}, b_i});
    // Dropping the low fraction bits truncates toward minus infinity
    assign prod_acc      = prod_full[ACC_W+WIDTH-1:WIDTH];
    assign w_unused_prod = ^{prod_full[2*DW-1:ACC_W+WIDTH], prod_full[WIDTH-1:0]};

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + prod_acc;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_hi  = acc_q[ACC_W-1:DW-1];
    assign hi_same = (&acc_hi) | ~(|acc_hi);
    assign ovf_o   = ~hi_same;
    assign sat_o   = hi_same       ? acc_q[DW-1:0] :
                     acc_q[ACC_W-1] ? {1'b1, {(DW-1){1'b0}}} :
                                      {1'b0, {(DW-1){1'b1}}};

endmodule
`default_nettype wire

// File: rtl/notch_inverse_equalizer.sv
`default_nettype none
// ============================================================================
// Module  : notch_inverse_equalizer
// Brief   : Time-multiplexed inverse of the DEM-DAC noise-shaping notch.
// Revision: 1.0
// ============================================================================
module notch_inverse_equalizer
    import notch_inverse_equalizer_pkg::*;
#(
    parameter int                 WIDTH = EQ_WIDTH,
    parameter int                 ACC_W = EQ_ACC_W,
    parameter logic [2*WIDTH-1:0] D1    = EQ_D1,
    parameter logic [2*WIDTH-1:0] D2    = EQ_D2,
    parameter logic [2*WIDTH-1:0] C1    = EQ_C1,
    parameter logic [2*WIDTH-1:0] C2    = EQ_C2
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     x_in_i,
    input  logic                 clear_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [2*WIDTH-1:0]   w_out_o,
    output logic [WIDTH-1:0]     w_int_o,
    output logic                 overflow_o
);

    localparam int              DW     = 2 * WIDTH;
    localparam logic [DW-1:0]   ONE    = {{(WIDTH-1){1'b0}}, 1'b1, {WIDTH{1'b0}}};
    localparam logic [DW-1:0]   NEG_C1 = -C1;
    localparam logic [DW-1:0]   NEG_C2 = -C2;

    eq_state_t     state_q, state_d;
    logic [2:0]    step_q, step_d;
    logic [DW-1:0] y_q, y_d;
    logic [DW-1:0] y1_q, y1_d;
    logic [DW-1:0] y2_q, y2_d;
    logic [DW-1:0] w1_q, w1_d;
    logic [DW-1:0] w2_q, w2_d;
    logic [DW-1:0] w_out_q, w_out_d;
    logic          ovf_q, ovf_d;
    logic          out_valid_q, out_valid_d;

    logic          accept;
    logic [DW-1:0] mac_a;
    logic [DW-1:0] mac_b;
    logic [DW-1:0] mac_sat;
    logic          mac_ovf;

    assign accept = (state_q == IDLE) && in_valid_i && !clear_i;

    always_comb begin
        mac_a = '0;
        mac_b = '0;
        case (step_q)
            3'd0: begin mac_a = ONE;    mac_b = y_q;  end
            3'd1: begin mac_a = D1;     mac_b = y1_q; end
            3'd2: begin mac_a = D2;     mac_b = y2_q; end
            3'd3: begin mac_a = NEG_C1; mac_b = w1_q; end
            3'd4: begin mac_a = NEG_C2; mac_b = w2_q; end
            default: begin mac_a = '0;  mac_b = '0;   end
        endcase
    end

    notch_inverse_equalizer_fx_mac_sat #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .clr_i    (clear_i || accept),
        .en_i     (state_q == MAC),
        .a_i      (mac_a),
        .b_i      (mac_b),
        .sat_o    (mac_sat),
        .ovf_o    (mac_ovf)
    );

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        y_d         = y_q;
        y1_d        = y1_q;
        y2_d        = y2_q;
        w1_d        = w1_q;
        w2_d        = w2_q;
        w_out_d     = w_out_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    y_d     = {x_in_i, {WIDTH{1'b0}}};
                    step_d  = 3'd0;
                    state_d = MAC;
                end
            end
            MAC: begin
                if (step_q == EQ_LAST_STEP) begin
                    state_d = SAT;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            SAT: begin
                w_out_d = mac_sat;
                ovf_d   = mac_ovf;
                y2_d    = y1_q;
                y1_d    = y_q;
                w2_d    = w1_q;
                w1_d    = mac_sat;
                state_d = HOLD;
            end
            HOLD: begin
                // First HOLD cycle raises the registered valid; the handshake follows it
                if (out_valid_q && out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clear_i) begin
            state_d     = IDLE;
            step_d      = 3'd0;
            y_d         = '0;
            y1_d        = '0;
            y2_d        = '0;
            w1_d        = '0;
            w2_d        = '0;
            w_out_d     = '0;
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= IDLE;
            step_q      <= 3'd0;
            y_q         <= '0;
            y1_q        <= '0;
            y2_q        <= '0;
            w1_q        <= '0;
            w2_q        <= '0;
            w_out_q     <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            y_q         <= y_d;
            y1_q        <= y1_d;
            y2_q        <= y2_d;
            w1_q        <= w1_d;
            w2_q        <= w2_d;
            w_out_q     <= w_out_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = out_valid_q;
    assign w_out_o     = w_out_q;
    assign w_int_o     = w_out_q[DW-1:WIDTH];
    assign overflow_o  = ovf_q;

endmodule
`default_nettype wire
